debounce_scan_scheduler: RTL and testbench

- Time-multiplexes one shared spike-filter update datapath across CHANNELS raw inputs (buttons, switches, GPIO).
- Per-channel filter state is held in a register array.
- A prescaler generates sample ticks; each tick launches a scan that updates one channel per clock.
- Output level changes are queued in a small event FIFO drained through a valid/ready handshake.

---
 rtl/debounce_scan_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_debounce_scan_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scan_scheduler.sv
// Scanned spike filter for CHANNELS raw inputs with a shared update datapath.
// Level changes are queued in a small event FIFO behind a valid/ready handshake.
module debounce_scan_scheduler #(
    parameter int   CHANNELS      = 8,
    parameter int   WIDTH         = 2,
    parameter int   PRESCALE      = 1000,
    parameter logic INITIAL_VALUE = 1'b1,
    parameter int   EVENT_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [CHANNELS-1:0]         in,
    output logic [CHANNELS-1:0]         out,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [$clog2(CHANNELS)-1:0] event_channel,
    output logic                        event_level,
    output logic                        scanning,
    output logic                        overflow,
    input  logic                        overflow_clr
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam int PW    = $clog2(PRESCALE);
    localparam int AW    = $clog2(EVENT_DEPTH);

    localparam logic [WIDTH-1:0]    CNT_MAX    = '1;
    localparam logic [WIDTH-1:0]    CNT_INIT   = {WIDTH{INITIAL_VALUE}};
    localparam logic [CHANNELS-1:0] OUT_INIT   = {CHANNELS{INITIAL_VALUE}};
    localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(CHANNELS - 1);
    localparam logic [AW:0]         FIFO_FULL  = (AW + 1)'(EVENT_DEPTH);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] channel;
        logic             level;
    } event_t;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] snapshot;
    logic [WIDTH-1:0]    cnt [CHANNELS];

    logic [PW-1:0]       presc;
    logic                tick;

    state_t              state;
    logic [IDX_W-1:0]    idx;

    logic [WIDTH-1:0]    c_cur;
    logic [WIDTH-1:0]    c_next;
    logic                s_cur;
    logic                out_cur;
    logic                out_next;
    logic                push;
    event_t              ev_in;

    event_t              mem [EVENT_DEPTH];
    event_t              head;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [AW:0]         count_next;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic                overrun;

    // Two-flop synchronizer, free running regardless of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= OUT_INIT;
            sync2 <= OUT_INIT;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (enable) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    assign tick = enable && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            snapshot <= OUT_INIT;
            scanning <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        snapshot <= sync2;
                        idx      <= '0;
                        state    <= SCAN;
                        scanning <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx == IDX_LAST) begin
                        idx      <= '0;
                        state    <= IDLE;
                        scanning <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    scanning <= 1'b0;
                end
            endcase
        end
    end

    // Shared filter datapath; the saturation clause overrides the decay clause.
    always_comb begin
        c_cur    = cnt[idx];
        s_cur    = snapshot[idx];
        out_cur  = out[idx];
        c_next   = c_cur;
        out_next = out_cur;
        if (c_cur == '0) begin
            out_next = 1'b0;
        end else if (!s_cur) begin
            c_next = c_cur - 1'b1;
        end
        if (c_cur == CNT_MAX) begin
            out_next = 1'b1;
        end else if (s_cur) begin
            c_next = c_cur + 1'b1;
        end
        push          = (state == SCAN) && (out_next != out_cur);
        ev_in.channel = idx;
        ev_in.level   = out_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt[k] <= CNT_INIT;
            end
            out <= OUT_INIT;
        end else if (state == SCAN) begin
            cnt[idx] <= c_next;
            out[idx] <= out_next;
        end
    end

    assign full    = (count == FIFO_FULL);
    assign pop     = event_valid && event_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign overrun = tick && (state == SCAN);

    always_comb begin
        count_next = count;
        unique case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // A push into a full FIFO that is also popping reuses the slot being read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= ev_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            event_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            event_valid <= (count_next != '0);
        end
    end

    assign head          = mem[rd_ptr];
    assign event_channel = head.channel;
    assign event_level   = head.level;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop || overrun) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// Directed bench for debounce_scan_scheduler (4 channels, prescale 16).
// Expected events are queued at stimulus time and matched on handshake.
module tb_debounce_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] din;
    logic [3:0] out;
    logic       event_valid;
    logic       event_ready;
    logic [1:0] event_channel;
    logic       event_level;
    logic       scanning;
    logic       overflow;
    logic       overflow_clr;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int ecnt   = 0;
    bit seen;

    typedef struct {
        int ch;
        int lvl;
    } ev_t;

    ev_t sb[$];

    always #5 clk = ~clk;

    debounce_scan_scheduler #(
        .CHANNELS(4),
        .WIDTH(2),
        .PRESCALE(16),
        .INITIAL_VALUE(1'b1),
        .EVENT_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .in(din),
        .out(out),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_channel(event_channel),
        .event_level(event_level),
        .scanning(scanning),
        .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    // Edges elapsed since reset release; the prescaler tracks this while enabled.
    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int e);
        while (ecnt < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int ch, input int lvl);
        ev_t e;
        e.ch  = ch;
        e.lvl = lvl;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst && event_valid && event_ready) begin
            total++;
            assert (sb.size() != 0) passed++;
            else begin
                failed++;
                $error("FAIL event_unexpected: observed ch %0d level %0d expected none",
                       event_channel, event_level);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("event_channel", 32'(event_channel), e.ch);
                chk("event_level", 32'(event_level), e.lvl);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b1;
        event_ready  = 1'b1;
        overflow_clr = 1'b0;
        din          = 4'b1011;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(out), 32'hf);
        chk("rst_valid", 32'(event_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_scanning", 32'(scanning), 0);

        // Steady low on ch2 falls on the 4th scan.
        expect_ev(2, 0);
        rst = 1'b0;
        goto(15); chk("pre_tick_idle", 32'(scanning), 0);
        goto(16); chk("scan_start", 32'(scanning), 1);
        goto(19); chk("scan_last", 32'(scanning), 1);
        goto(20); chk("scan_end", 32'(scanning), 0);
        goto(66); chk("fall_not_yet", 32'(out), 32'hf);
        goto(67);
        chk("fall_out", 32'(out), 32'hb);
        chk("fall_valid", 32'(event_valid), 1);
        chk("fall_head_ch", 32'(event_channel), 2);
        chk("fall_head_lvl", 32'(event_level), 0);
        goto(68); chk("fall_popped", 32'(event_valid), 0);

        // One-tick glitch on ch1 is absorbed.
        goto(70); din = 4'b1001;
        goto(82); chk("glitch_cnt_dec", 32'(dut.cnt[1]), 2);
        goto(86); din = 4'b1011;
        goto(98); chk("glitch_cnt_inc", 32'(dut.cnt[1]), 3);
        goto(150);
        chk("glitch_out", 32'(out), 32'hb);
        chk("glitch_no_events", sb.size(), 0);

        // Four changes in one scan with backpressure, then a dropped fifth.
        event_ready = 1'b0;
        din = 4'b0100;
        expect_ev(0, 0);
        expect_ev(1, 0);
        expect_ev(2, 1);
        expect_ev(3, 0);
        goto(208); chk("order_before", 32'(out), 32'hb);
        goto(212);
        chk("order_out", 32'(out), 32'h4);
        chk("order_valid", 32'(event_valid), 1);
        chk("order_head_ch", 32'(event_channel), 0);
        chk("order_head_lvl", 32'(event_level), 0);
        chk("order_no_ovf", 32'(overflow), 0);
        goto(213); din = 4'b0110;
        goto(273);
        chk("drop_pre_ovf", 32'(overflow), 0);
        chk("head_stable_ch", 32'(event_channel), 0);
        goto(274);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_out", 32'(out), 32'h6);
        chk("drop_head_ch", 32'(event_channel), 0);
        chk("drop_head_lvl", 32'(event_level), 0);
        goto(276); overflow_clr = 1'b1;
        goto(277);
        chk("ovf_cleared", 32'(overflow), 0);
        overflow_clr = 1'b0;
        event_ready  = 1'b1;
        goto(285);
        chk("drain_valid", 32'(event_valid), 0);
        chk("drain_sb", sb.size(), 0);

        // Push into a full FIFO in the same cycle as a pop.
        goto(290);
        event_ready = 1'b0;
        din = 4'b1001;
        expect_ev(0, 1);
        expect_ev(1, 0);
        expect_ev(2, 0);
        expect_ev(3, 1);
        expect_ev(1, 1);
        goto(356);
        chk("full_out", 32'(out), 32'h9);
        chk("full_valid", 32'(event_valid), 1);
        goto(357); din = 4'b1011;
        goto(417); event_ready = 1'b1;
        goto(418);
        event_ready = 1'b0;
        chk("pp_no_ovf", 32'(overflow), 0);
        chk("pp_count", 32'(dut.count), 4);
        chk("pp_out", 32'(out), 32'hb);
        chk("pp_head_ch", 32'(event_channel), 1);
        chk("pp_head_lvl", 32'(event_level), 0);
        goto(420); event_ready = 1'b1;
        goto(425);
        chk("pp_drain_valid", 32'(event_valid), 0);
        chk("pp_drain_sb", sb.size(), 0);

        // Disable mid-scan, resume, then reset mid-scan with events queued.
        event_ready = 1'b0;
        din = 4'b1110;
        goto(433); enable = 1'b0;
        goto(435); chk("dis_scan_runs", 32'(scanning), 1);
        goto(436); chk("dis_scan_done", 32'(scanning), 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (scanning) seen = 1'b1;
        end
        chk("dis_no_scan", 32'(seen), 0);
        goto(480); enable = 1'b1;
        goto(494); chk("resume_pre", 32'(scanning), 0);
        goto(495); chk("resume_scan", 32'(scanning), 1);
        goto(530);
        chk("queued_out", 32'(out), 32'he);
        chk("queued_valid", 32'(event_valid), 1);
        chk("queued_head_ch", 32'(event_channel), 0);
        goto(544);
        chk("mid_scan", 32'(scanning), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_out", 32'(out), 32'hf);
        chk("mrst_valid", 32'(event_valid), 0);
        chk("mrst_scanning", 32'(scanning), 0);
        chk("mrst_overflow", 32'(overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        event_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(event_valid), 0);
        chk("post_rst_out", 32'(out), 32'hf);
        chk("final_sb", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
